// File: rtl/channel_burst_multiplexer.sv
// channel_burst_multiplexer
//   Merges CHANN per-channel word streams onto one output stream. Every channel
//   has its own buffer. Data leaves in framed bursts: one header word
//   {channel id, zeros, len-1} and then len payload words, with 1 <= len <= MAX_BURST.
//   Channels are granted round-robin. A channel becomes eligible when it holds a
//   full burst, or when it holds a partial burst that has aged TIMEOUT cycles.
//   channel_enable masks grants only. Buffers accept writes whatever the mask is.
//
// Ports
//   clk, com_rst_n             clock; asynchronous active-low reset
//   fifo_out_valid_channel     per-channel input word valid
//   fifo_out_ready_channel     per-channel ready (buffer not full); 0 during reset
//   fifo_out_data_channel      per-channel input words
//   channel_enable             per-channel grant enable
//   fifo_out_valid/ready/data  merged output stream (header or payload)
//   fsm_state                  current burst FSM state (0 IDLE, 1 HEADER, 2 DATA)
//
// Handshake: a word moves on every rising clk edge where valid && ready are
// both high. A source holds valid and data stable until that edge; ready may
// change freely and has no combinational dependency on valid.
module channel_burst_multiplexer #(
  parameter int WIDTH      = 16,
  parameter int CHANN      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 8,
  parameter int TIMEOUT    = 32
) (
  input  logic                        clk,
  input  logic                        com_rst_n,
  input  logic [CHANN-1:0]            fifo_out_valid_channel,
  output logic [CHANN-1:0]            fifo_out_ready_channel,
  input  logic [CHANN-1:0][WIDTH-1:0] fifo_out_data_channel,
  input  logic [CHANN-1:0]            channel_enable,
  output logic                        fifo_out_valid,
  input  logic                        fifo_out_ready,
  output logic [WIDTH-1:0]            fifo_out_data,
  output logic [1:0]                  fsm_state
);

  localparam int CW = (CHANN > 1) ? $clog2(CHANN) : 1;
  localparam int LW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] BURST_N  = NW'(MAX_BURST);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);
  localparam logic [CW:0]   CHANN_W  = (CW+1)'(CHANN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   ch, ch_next;          // channel owning the current burst
  logic [LW-1:0]   len_m1, len_m1_next;  // burst length minus one, frozen at grant
  logic [LW-1:0]   cnt, cnt_next;        // payload words already sent
  logic [CW-1:0]   rr, rr_next;          // last granted channel
  logic            burst_done;

  logic [CHANN-1:0] full, push, pop, eligible;
  logic [NW-1:0]    fill [CHANN];
  logic [WIDTH-1:0] head [CHANN];

  // ---------------------------------------------------------------------------
  // Per-channel buffer and age timer
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < CHANN; g++) begin : g_ch
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [NW-1:0]    fill_r;
    logic [TW-1:0]    timer;

    // Ready comes only from the registered fill level. A full buffer therefore
    // refuses a push even in a cycle where it is popped.
    assign full[g] = (fill_r == DEPTH_N);
    assign push[g] = fifo_out_valid_channel[g] && !full[g];
    assign pop[g]  = (state == DATA) && (ch == CW'(g)) && fifo_out_ready;
    assign eligible[g] = channel_enable[g] &&
                         ((fill_r >= BURST_N) || ((fill_r != '0) && (timer == TMAX)));
    assign fill[g] = fill_r;
    assign head[g] = mem[rd_ptr];

    always_ff @(posedge clk) begin
      if (push[g]) mem[wr_ptr] <= fifo_out_data_channel[g];
    end

    always_ff @(posedge clk or negedge com_rst_n) begin
      if (!com_rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill_r <= '0;
        timer  <= '0;
      end else begin
        if (push[g]) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        if (pop[g])  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        if (push[g] && !pop[g])      fill_r <= fill_r + 1'b1;
        else if (pop[g] && !push[g]) fill_r <= fill_r - 1'b1;
        // The age restarts whenever this channel's burst completes. Any words
        // left over then wait a fresh TIMEOUT unless they make up a full burst.
        if ((fill_r == '0) || (burst_done && (ch == CW'(g)))) timer <= '0;
        else if (timer != TMAX)                             timer <= timer + 1'b1;
      end
    end
  end

  assign fifo_out_ready_channel = ~full & {CHANN{com_rst_n}};

  // ---------------------------------------------------------------------------
  // Round-robin pick: first eligible channel after rr, wrapping modulo CHANN
  // ---------------------------------------------------------------------------
  logic          grant_found;
  logic [CW-1:0] grant_idx;
  logic [CW:0]   scan;
  logic [CW-1:0] scan_idx;
  logic [LW-1:0] grant_len_m1;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan        = '0;
    scan_idx    = '0;
    for (int k = 1; k <= CHANN; k++) begin
      scan = {1'b0, rr} + (CW+1)'(k);
      if (scan >= CHANN_W) scan = scan - CHANN_W;
      scan_idx = scan[CW-1:0];
      if (!grant_found && eligible[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign grant_len_m1 = (fill[grant_idx] >= BURST_N) ? LW'(MAX_BURST - 1)
                                                     : LW'(fill[grant_idx] - 1'b1);

  // ---------------------------------------------------------------------------
  // Burst FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge com_rst_n) begin
    if (!com_rst_n) begin
      state  <= IDLE;
      ch     <= '0;
      len_m1 <= '0;
      cnt    <= '0;
      rr     <= CW'(CHANN - 1);
    end else begin
      state  <= state_next;
      ch     <= ch_next;
      len_m1 <= len_m1_next;
      cnt    <= cnt_next;
      rr     <= rr_next;
    end
  end

  always_comb begin
    state_next     = state;
    ch_next        = ch;
    len_m1_next    = len_m1;
    cnt_next       = cnt;
    rr_next        = rr;
    burst_done     = 1'b0;
    fifo_out_valid = 1'b0;
    fifo_out_data  = '0;
    case (state)
      IDLE: begin
        if (grant_found) begin
          ch_next     = grant_idx;
          len_m1_next = grant_len_m1;
          rr_next     = grant_idx;
          state_next  = HEADER;
        end
      end
      HEADER: begin
        fifo_out_valid = 1'b1;
        fifo_out_data[WIDTH-1 -: CW] = ch;
        fifo_out_data[LW-1:0]        = len_m1;
        if (fifo_out_ready) begin
          cnt_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        fifo_out_valid = 1'b1;
        fifo_out_data  = head[ch];
        if (fifo_out_ready) begin
          cnt_next = cnt + 1'b1;
          if (cnt == len_m1) begin
            burst_done = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fsm_state = state;

endmodule
